// File: rtl/intersection_scheduler_pkg.sv
// Shared phase codes, arm indices and scheduler state encoding for the intersection.
// The arm light controllers decode the same phase codes.
package intersection_scheduler_pkg;

  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned ARM_IDX_W = 2;
  localparam int unsigned NUM_ARMS  = 4;

  typedef logic [PHASE_W-1:0]   phase_t;
  typedef logic [ARM_IDX_W-1:0] arm_t;

  localparam phase_t PH_N       = 3'b000;
  localparam phase_t PH_E       = 3'b001;
  localparam phase_t PH_S       = 3'b010;
  localparam phase_t PH_W       = 3'b011;
  localparam phase_t PH_ALL_RED = 3'b100;
  localparam phase_t PH_NIGHT   = 3'b111;

  localparam arm_t ARM_N = 2'd0;
  localparam arm_t ARM_E = 2'd1;
  localparam arm_t ARM_S = 2'd2;
  localparam arm_t ARM_W = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_GREEN = 2'd1,
    ST_NIGHT = 2'd2
  } sched_state_t;

  // Green phase code for an arm index.
  function automatic phase_t green_code(input arm_t arm);
    phase_t code;
    case (arm)
      ARM_N:   code = PH_N;
      ARM_E:   code = PH_E;
      ARM_S:   code = PH_S;
      default: code = PH_W;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/intersection_scheduler_blink_gen.sv
// Night blink generator: toggles every BLINK_TICKS ticks while enabled.
// start loads the first half-period high; clr forces low.
module intersection_scheduler_blink_gen #(
  parameter int unsigned BLINK_TICKS = 1,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic en,
  input  logic start,
  input  logic clr,
  output logic blink
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W:0]   half_inc;
  logic             half_done;

  assign half_inc  = {1'b0, half_cnt} + CW1'(1);
  assign half_done = half_inc >= CW1'(BLINK_TICKS);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      blink    <= 1'b0;
      half_cnt <= '0;
    end else if (start) begin
      blink    <= 1'b1;
      half_cnt <= '0;
    end else if (en && tick) begin
      if (half_done) begin
        blink    <= ~blink;
        half_cnt <= '0;
      end else begin
        half_cnt <= CNT_W'(half_inc);
      end
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Central intersection sequencer: demand-skipping green rotation with all-red
// clearance, night flashing mode and a per-phase watchdog.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int unsigned CLEAR_TICKS     = 2,
  parameter int unsigned MAX_PHASE_TICKS = 40,
  parameter int unsigned BLINK_TICKS     = 1,
  parameter int unsigned CNT_W           = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                ready_N,
  input  logic                ready_E,
  input  logic                ready_S,
  input  logic                ready_W,
  input  logic [NUM_ARMS-1:0] demand,
  input  logic                night_mode,
  output logic [PHASE_W-1:0]  stare_semafor,
  output logic                blink,
  output logic                timeout_err,
  output logic                phase_start
);

  localparam int unsigned CW1 = CNT_W + 1;

  sched_state_t        state_q, state_d;
  arm_t                dir_q, dir_d;
  arm_t                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_tick;
  logic [CNT_W:0]      cnt_inc;
  logic                clear_done, wd_expire, ready_match;
  logic [NUM_ARMS-1:0] ready_vec;
  phase_t              stare_d;
  logic                timeout_d, phase_start_d;
  logic                blink_start, blink_clr, blink_en;

  // First demanding arm after last, in N->E->S->W order; plain rotation when idle.
  function automatic arm_t next_dir(input arm_t last, input logic [NUM_ARMS-1:0] dem);
    arm_t cand;
    arm_t pick;
    pick = last + ARM_IDX_W'(1);
    for (int i = int'(NUM_ARMS); i >= 1; i--) begin
      cand = last + ARM_IDX_W'(i);
      if (dem[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign cnt_inc     = {1'b0, cnt_q} + CW1'(1);
  assign cnt_tick    = (tick && !(&cnt_q)) ? CNT_W'(cnt_inc) : cnt_q;
  assign clear_done  = tick && (cnt_inc >= CW1'(CLEAR_TICKS));
  assign wd_expire   = tick && (cnt_inc >= CW1'(MAX_PHASE_TICKS));
  assign ready_vec   = {ready_W, ready_S, ready_E, ready_N};
  assign ready_match = ready_vec[dir_q];

  // Next-state, next-output and blink control.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    last_d        = last_q;
    cnt_d         = cnt_tick;
    timeout_d     = timeout_err;
    phase_start_d = 1'b0;
    stare_d       = PH_ALL_RED;
    blink_start   = 1'b0;
    blink_clr     = 1'b0;
    blink_en      = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (clear_done) begin
          cnt_d = '0;
          if (night_mode) begin
            state_d = ST_NIGHT;
          end else begin
            state_d       = ST_GREEN;
            dir_d         = next_dir(last_q, demand);
            phase_start_d = 1'b1;
          end
        end
      end
      ST_GREEN: begin
        // A matching ready outranks a watchdog expiry in the same cycle.
        if (ready_match) begin
          state_d = ST_CLEAR;
          last_d  = dir_q;
          cnt_d   = '0;
        end else if (wd_expire) begin
          state_d   = ST_CLEAR;
          last_d    = dir_q;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      ST_NIGHT: begin
        cnt_d = '0;
        if (!night_mode) state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      ST_GREEN: stare_d = green_code(dir_d);
      ST_NIGHT: stare_d = PH_NIGHT;
      default:  stare_d = PH_ALL_RED;
    endcase

    blink_en    = (state_q == ST_NIGHT);
    blink_start = (state_q != ST_NIGHT) && (state_d == ST_NIGHT);
    blink_clr   = (state_d != ST_NIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      dir_q         <= ARM_N;
      last_q        <= ARM_W;
      cnt_q         <= '0;
      stare_semafor <= PH_ALL_RED;
      timeout_err   <= 1'b0;
      phase_start   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      stare_semafor <= stare_d;
      timeout_err   <= timeout_d;
      phase_start   <= phase_start_d;
    end
  end

  intersection_scheduler_blink_gen #(
    .BLINK_TICKS (BLINK_TICKS),
    .CNT_W       (CNT_W)
  ) u_blink_gen (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .en    (blink_en),
    .start (blink_start),
    .clr   (blink_clr),
    .blink (blink)
  );

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_intersection_scheduler;

  localparam int CLEAR_T = 2;
  localparam int MAX_T   = 40;
  localparam int BLINK_T = 1;

  logic       clk = 1'b0;
  logic       rst, tick, ready_N, ready_E, ready_S, ready_W, night_mode;
  logic [3:0] demand;
  logic [2:0] stare_semafor;
  logic       blink, timeout_err, phase_start;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = clearance, 1 = green, 2 = night.
  int         m_mode, m_ticks, m_last, m_arm, m_half;
  logic       m_blink, m_to, m_ps;
  logic [2:0] m_code;

  intersection_scheduler #(
    .CLEAR_TICKS     (CLEAR_T),
    .MAX_PHASE_TICKS (MAX_T),
    .BLINK_TICKS     (BLINK_T),
    .CNT_W           (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .ready_N       (ready_N),
    .ready_E       (ready_E),
    .ready_S       (ready_S),
    .ready_W       (ready_W),
    .demand        (demand),
    .night_mode    (night_mode),
    .stare_semafor (stare_semafor),
    .blink         (blink),
    .timeout_err   (timeout_err),
    .phase_start   (phase_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int pick_arm(input int last, input logic [3:0] dem);
    for (int k = 1; k <= 4; k++)
      if (dem[(last + k) % 4]) return (last + k) % 4;
    return (last + 1) % 4;
  endfunction

  task automatic model_update();
    logic [3:0] rdy;
    rdy  = {ready_W, ready_S, ready_E, ready_N};
    m_ps = 1'b0;
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_last = 3; m_half = 0;
      m_blink = 1'b0; m_to = 1'b0; m_code = 3'b100;
    end else if (m_mode == 0) begin
      if (tick) m_ticks++;
      if (tick && m_ticks >= CLEAR_T) begin
        m_ticks = 0;
        if (night_mode) begin
          m_mode = 2; m_blink = 1'b1; m_half = 0; m_code = 3'b111;
        end else begin
          m_arm = pick_arm(m_last, demand);
          m_mode = 1; m_code = 3'(m_arm); m_ps = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (tick && m_ticks < 63) m_ticks++;
      if (rdy[m_arm] || (tick && m_ticks >= MAX_T)) begin
        if (!rdy[m_arm]) m_to = 1'b1;
        m_last = m_arm; m_mode = 0; m_ticks = 0; m_code = 3'b100;
      end
    end else begin
      if (!night_mode) begin
        m_mode = 0; m_ticks = 0; m_blink = 1'b0; m_code = 3'b100;
      end else if (tick) begin
        m_half++;
        if (m_half >= BLINK_T) begin
          m_blink = !m_blink; m_half = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {ready_W, ready_S, ready_E, ready_N} = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; night_mode = 1'b0; demand = 4'b0000;
    set_ready(4'b0000);
    step();
    rst = 1'b0;
  endtask

  // Walk the rotation (tick held high) until the model shows a green on arm.
  task automatic goto_green(input int arm, output bit reached);
    int n = 0;
    tick = 1'b1;
    while (!(m_mode == 1 && m_arm == arm) && n < 400) begin
      set_ready((m_mode == 1) ? 4'(1 << m_arm) : 4'b0000);
      step();
      n++;
    end
    set_ready(4'b0000);
    reached = (m_mode == 1 && m_arm == arm);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; night_mode = 1'b1; demand = 4'($urandom);
    set_ready(4'($urandom));
    step(); step();
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL reset_code: got %b want 100", stare_semafor); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", blink); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    checks++; if (phase_start !== 1'b0) begin errors++; $display("FAIL reset_phase_start: got %b want 0", phase_start); end
    rst = 1'b0; night_mode = 1'b0; set_ready(4'b0000);
  endtask

  task automatic test_rotation();
    logic [2:0] seq[$];
    logic [2:0] want[10] = '{3'd4, 3'd0, 3'd4, 3'd1, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd0};
    logic [2:0] g;
    int ps_cnt = 0;
    int n = 0;
    do_reset();
    demand = 4'b1111; tick = 1'b1;
    seq.push_back(stare_semafor);
    while (seq.size() < 10 && n < 300) begin
      set_ready((m_mode == 1 && m_ticks == 3) ? 4'(1 << m_arm) : 4'b0000);
      step(); n++;
      if (phase_start === 1'b1) ps_cnt++;
      if (stare_semafor !== seq[$]) seq.push_back(stare_semafor);
    end
    set_ready(4'b0000);
    for (int i = 0; i < 10; i++) begin
      g = (i < seq.size()) ? seq[i] : 3'bxxx;
      checks++; if (g !== want[i]) begin errors++; $display("FAIL rotation_seq[%0d]: got %b want %b", i, g, want[i]); end
    end
    checks++; if (ps_cnt != 5) begin errors++; $display("FAIL rotation_phase_start_count: got %0d want 5", ps_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rotation_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_skip();
    logic [2:0] seq[$];
    logic [2:0] want[4] = '{3'd4, 3'd2, 3'd4, 3'd2};
    logic [2:0] g;
    int ps_cnt = 0;
    int n = 0;
    do_reset();
    demand = 4'b0100; tick = 1'b1;
    seq.push_back(stare_semafor);
    while (seq.size() < 4 && n < 200) begin
      set_ready((m_mode == 1 && m_ticks == 2) ? 4'(1 << m_arm) : 4'b0000);
      step(); n++;
      if (phase_start === 1'b1) ps_cnt++;
      if (stare_semafor !== seq[$]) seq.push_back(stare_semafor);
    end
    set_ready(4'b0000);
    for (int i = 0; i < 4; i++) begin
      g = (i < seq.size()) ? seq[i] : 3'bxxx;
      checks++; if (g !== want[i]) begin errors++; $display("FAIL skip_seq[%0d]: got %b want %b", i, g, want[i]); end
    end
    checks++; if (ps_cnt != 2) begin errors++; $display("FAIL skip_phase_start_count: got %0d want 2", ps_cnt); end
  endtask

  task automatic test_ignore_other();
    bit ok;
    do_reset();
    demand = 4'b1111;
    goto_green(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_reach_E: got no green E want green E"); end
    checks++; if (phase_start !== 1'b1) begin errors++; $display("FAIL ignore_phase_start: got %b want 1", phase_start); end
    tick = 1'b0;
    set_ready(4'b1001);
    step();
    checks++; if (stare_semafor !== 3'b001) begin errors++; $display("FAIL ignore_other_ready: got %b want 001", stare_semafor); end
    checks++; if (phase_start !== 1'b0) begin errors++; $display("FAIL ignore_phase_start_drop: got %b want 0", phase_start); end
    set_ready(4'b0010);
    step();
    set_ready(4'b0000);
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL ignore_ready_E: got %b want 100", stare_semafor); end
  endtask

  task automatic test_watchdog();
    bit ok;
    bit early_bad = 1'b0;
    do_reset();
    demand = 4'b1111;
    goto_green(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wd_reach_N: got no green N want green N"); end
    for (int k = 1; k < MAX_T; k++) begin
      step();
      if (timeout_err !== 1'b0 || stare_semafor !== 3'b000) early_bad = 1'b1;
    end
    checks++; if (early_bad) begin errors++; $display("FAIL wd_early: got early timeout or phase change want green N held 39 ticks"); end
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_flag: got %b want 1", timeout_err); end
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL wd_clear: got %b want 100", stare_semafor); end
    step(); step();
    checks++; if (stare_semafor !== 3'b001) begin errors++; $display("FAIL wd_next_arm: got %b want 001", stare_semafor); end
    repeat (10) step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", timeout_err); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_rst_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_watchdog_tie();
    bit ok;
    do_reset();
    demand = 4'b1111;
    goto_green(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_reach_N: got no green N want green N"); end
    repeat (MAX_T - 1) step();
    set_ready(4'b0001);
    step();
    set_ready(4'b0000);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tie_timeout: got %b want 0", timeout_err); end
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL tie_clear: got %b want 100", stare_semafor); end
    step(); step();
    checks++; if (stare_semafor !== 3'b001) begin errors++; $display("FAIL tie_next_arm: got %b want 001", stare_semafor); end
  endtask

  task automatic test_night();
    bit ok;
    bit held_bad = 1'b0;
    logic want_blink;
    do_reset();
    demand = 4'b1111;
    goto_green(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL night_reach_S: got no green S want green S"); end
    night_mode = 1'b1;
    repeat (5) begin
      step();
      if (stare_semafor !== 3'b010) held_bad = 1'b1;
    end
    checks++; if (held_bad) begin errors++; $display("FAIL night_green_truncated: got phase change want 010 held"); end
    set_ready(4'b0100);
    step();
    set_ready(4'b0000);
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL night_clear1: got %b want 100", stare_semafor); end
    step();
    checks++; if (stare_semafor !== 3'b100) begin errors++; $display("FAIL night_clear2: got %b want 100", stare_semafor); end
    step();
    checks++; if (stare_semafor !== 3'b111) begin errors++; $display("FAIL night_code: got %b want 111", stare_semafor); end
    want_blink = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++; if (blink !== want_blink) begin errors++; $display("FAIL night_blink[%0d]: got %b want %b", i, blink, want_blink); end
      want_blink = !want_blink;
    end
    night_mode = 1'b0;
    step();
    checks++; if (stare_semafor !== 3'b100 || blink !== 1'b0) begin errors++; $display("FAIL night_exit: got code %b blink %b want 100 blink 0", stare_semafor, blink); end
    step(); step();
    checks++; if (stare_semafor !== 3'b011) begin errors++; $display("FAIL night_next_arm: got %b want 011", stare_semafor); end
  endtask

  task automatic test_night_reset();
    bit ok;
    do_reset();
    demand = 4'b1111;
    goto_green(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nrst_reach_N: got no green N want green N"); end
    repeat (MAX_T) step();
    night_mode = 1'b1;
    step(); step();
    checks++; if (stare_semafor !== 3'b111 || timeout_err !== 1'b1) begin errors++; $display("FAIL nrst_pre: got code %b timeout %b want 111 timeout 1", stare_semafor, timeout_err); end
    rst = 1'b1;
    step();
    rst = 1'b0; night_mode = 1'b0;
    checks++; if ({stare_semafor, blink, timeout_err, phase_start} !== 6'b100_0_0_0) begin errors++; $display("FAIL nrst_post: got code %b blink %b timeout %b ps %b want 100 0 0 0", stare_semafor, blink, timeout_err, phase_start); end
  endtask

  task automatic test_random();
    do_reset();
    demand = 4'b1111;
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 599) == 0);
      tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 59) == 0) night_mode = !night_mode;
      if ($urandom_range(0, 9) == 0) demand = 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        case (b)
          0: ready_N = ($urandom_range(0, 24) == 0);
          1: ready_E = ($urandom_range(0, 24) == 0);
          2: ready_S = ($urandom_range(0, 24) == 0);
          default: ready_W = ($urandom_range(0, 24) == 0);
        endcase
      end
      step();
      checks++;
      if ({stare_semafor, blink, timeout_err, phase_start} !== {m_code, m_blink, m_to, m_ps}) begin
        errors++;
        $display("FAIL random_cycle %0d: got code %b blink %b timeout %b ps %b want code %b blink %b timeout %b ps %b",
                 c, stare_semafor, blink, timeout_err, phase_start, m_code, m_blink, m_to, m_ps);
      end
    end
    rst = 1'b0; night_mode = 1'b0; set_ready(4'b0000);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; night_mode = 1'b0; demand = 4'b0000;
    set_ready(4'b0000);
    m_mode = 0; m_ticks = 0; m_last = 3; m_arm = 0; m_half = 0;
    m_blink = 1'b0; m_to = 1'b0; m_ps = 1'b0; m_code = 3'b100;
    test_reset();
    test_rotation();
    test_skip();
    test_ignore_other();
    test_watchdog();
    test_watchdog_tie();
    test_night();
    test_night_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
